fdl_track_ctrl: RTL and testbench



---
 rtl/fdl_track_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fdl_track_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdl_track_ctrl.sv
// Fine delay line tracking controller.
// Filters phase-detector votes into fine up/down steps, drives the thermometer
// and one-hot encodings of the fine level, issues coarse carry/borrow pulses on
// fine wrap-around and reports lock from step-direction reversals.
//
// Handshake: pd_up is meaningful only in a cycle where pd_valid = 1. There is no
// back-pressure; samples that arrive in IDLE or while settling are dropped.
module fdl_track_ctrl #(
    parameter int N_FINE       = 6,
    parameter int FILT_TH      = 4,
    parameter int SETTLE       = 4,
    parameter int LOCK_TOGGLES = 4,
    parameter int INIT_LEVEL   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        pd_valid,
    input  logic                        pd_up,
    input  logic                        coarse_at_max,
    input  logic                        coarse_at_min,
    output logic [N_FINE-1:0]           therm_q,
    output logic [N_FINE:0]             sel_onehot,
    output logic [$clog2(N_FINE+1)-1:0] level,
    output logic                        coarse_inc,
    output logic                        coarse_dec,
    output logic                        locked
);

    localparam int LW = $clog2(N_FINE + 1);
    localparam int AW = $clog2(FILT_TH + 1) + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(LOCK_TOGGLES + 1);

    localparam logic [LW-1:0]        LVL_MAX     = LW'(N_FINE);
    localparam logic [LW-1:0]        LVL_ZERO    = '0;
    localparam logic [LW-1:0]        LVL_ONE     = LW'(1);
    localparam logic [LW-1:0]        LVL_INIT    = LW'(INIT_LEVEL);
    localparam logic signed [AW-1:0] ACC_ONE     = AW'(1);
    localparam logic signed [AW-1:0] ACC_TH      = AW'(FILT_TH);
    localparam logic signed [AW-1:0] ACC_NTH     = -ACC_TH;
    localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [SW-1:0]        SETTLE_ONE  = SW'(1);
    localparam logic [CW-1:0]        REV_MAX     = CW'(LOCK_TOGGLES);
    localparam logic [CW-1:0]        REV_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        SETTLING = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    state_t                state;
    dir_t                  last_dir;
    dir_t                  step_dir;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_upd;
    logic [SW-1:0]         settle_cnt;
    logic [CW-1:0]         rev_cnt;
    logic [CW-1:0]         rev_inc;
    logic                  hit_up;
    logic                  hit_dn;
    logic                  do_up;
    logic                  do_dn;
    logic                  wrap_up;
    logic                  wrap_dn;
    logic [LW-1:0]         lvl_nxt;

    // Level k fills k ones starting from the MSB.
    function automatic logic [N_FINE-1:0] therm_of(input logic [LW-1:0] k);
        logic [N_FINE-1:0] t;
        t = '0;
        for (int i = 0; i < N_FINE; i++) begin
            t[N_FINE-1-i] = (i < int'(k));
        end
        return t;
    endfunction

    // Bit k set when the level is k.
    function automatic logic [N_FINE:0] onehot_of(input logic [LW-1:0] k);
        logic [N_FINE:0] o;
        o = '0;
        for (int i = 0; i <= N_FINE; i++) begin
            o[i] = (int'(k) == i);
        end
        return o;
    endfunction

    // Vote filter and step decision for the current cycle.
    always_comb begin
        acc_upd = acc;
        hit_up  = 1'b0;
        hit_dn  = 1'b0;
        if (en && (state == TRACK) && pd_valid) begin
            acc_upd = pd_up ? (acc + ACC_ONE) : (acc - ACC_ONE);
            hit_up  = (acc_upd == ACC_TH);
            hit_dn  = (acc_upd == ACC_NTH);
        end
        do_up    = hit_up && (level != LVL_MAX);
        wrap_up  = hit_up && (level == LVL_MAX) && !coarse_at_max;
        do_dn    = hit_dn && (level != LVL_ZERO);
        wrap_dn  = hit_dn && (level == LVL_ZERO) && !coarse_at_min;
        step_dir = do_up ? DIR_UP : DIR_DN;
        rev_inc  = (rev_cnt == REV_MAX) ? rev_cnt : (rev_cnt + REV_ONE);
        lvl_nxt  = level;
        if (do_up) begin
            lvl_nxt = level + LVL_ONE;
        end else if (do_dn) begin
            lvl_nxt = level - LVL_ONE;
        end else if (wrap_up) begin
            lvl_nxt = LVL_ZERO;
        end else if (wrap_dn) begin
            lvl_nxt = LVL_MAX;
        end
    end

    // Control FSM with registered level, encodings, pulses and lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            settle_cnt <= '0;
            rev_cnt    <= '0;
            last_dir   <= DIR_NONE;
            level      <= LVL_INIT;
            therm_q    <= therm_of(LVL_INIT);
            sel_onehot <= onehot_of(LVL_INIT);
            coarse_inc <= 1'b0;
            coarse_dec <= 1'b0;
            locked     <= 1'b0;
        end else begin
            coarse_inc <= 1'b0;
            coarse_dec <= 1'b0;
            // Both encodings load from the same next level, so they never disagree.
            level      <= lvl_nxt;
            therm_q    <= therm_of(lvl_nxt);
            sel_onehot <= onehot_of(lvl_nxt);
            if (!en) begin
                state      <= IDLE;
                acc        <= '0;
                settle_cnt <= '0;
                rev_cnt    <= '0;
                last_dir   <= DIR_NONE;
                locked     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= TRACK;
                    end
                    TRACK: begin
                        // Any threshold hit, executed or saturated, restarts the filter.
                        acc <= (hit_up || hit_dn) ? '0 : acc_upd;
                        if (wrap_up || wrap_dn) begin
                            coarse_inc <= wrap_up;
                            coarse_dec <= wrap_dn;
                            state      <= SETTLING;
                            settle_cnt <= SETTLE_LOAD;
                            rev_cnt    <= '0;
                            last_dir   <= DIR_NONE;
                            locked     <= 1'b0;
                        end else if (do_up || do_dn) begin
                            last_dir <= step_dir;
                            if ((last_dir != DIR_NONE) && (last_dir != step_dir)) begin
                                rev_cnt <= rev_inc;
                                locked  <= (rev_inc == REV_MAX);
                            end else if (last_dir == step_dir) begin
                                rev_cnt <= '0;
                                locked  <= 1'b0;
                            end
                        end
                    end
                    SETTLING: begin
                        // Votes taken while the coarse line moves are meaningless.
                        acc <= '0;
                        if (settle_cnt == '0) begin
                            state <= TRACK;
                        end else begin
                            settle_cnt <= settle_cnt - SETTLE_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fdl_track_ctrl.sv
// Self-checking bench for fdl_track_ctrl: directed steps followed by a
// randomized phase, all compared against a rule-level reference model.
module tb_fdl_track_ctrl;

    localparam int N_FINE       = 6;
    localparam int FILT_TH      = 4;
    localparam int SETTLE       = 4;
    localparam int LOCK_TOGGLES = 4;
    localparam int INIT_LEVEL   = 0;
    localparam int LW           = $clog2(N_FINE + 1);
    localparam int EW           = LW + 3;

    logic                clk           = 1'b0;
    logic                rst_n         = 1'b0;
    logic                en            = 1'b0;
    logic                pd_valid      = 1'b0;
    logic                pd_up         = 1'b0;
    logic                coarse_at_max = 1'b0;
    logic                coarse_at_min = 1'b0;
    logic [N_FINE-1:0]   therm_q;
    logic [N_FINE:0]     sel_onehot;
    logic [LW-1:0]       level;
    logic                coarse_inc;
    logic                coarse_dec;
    logic                locked;

    fdl_track_ctrl #(
        .N_FINE       (N_FINE),
        .FILT_TH      (FILT_TH),
        .SETTLE       (SETTLE),
        .LOCK_TOGGLES (LOCK_TOGGLES),
        .INIT_LEVEL   (INIT_LEVEL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pd_valid      (pd_valid),
        .pd_up         (pd_up),
        .coarse_at_max (coarse_at_max),
        .coarse_at_min (coarse_at_min),
        .therm_q       (therm_q),
        .sel_onehot    (sel_onehot),
        .level         (level),
        .coarse_inc    (coarse_inc),
        .coarse_dec    (coarse_dec),
        .locked        (locked)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, kept as plain integers.
    int m_level;
    int m_acc;
    int m_settle;
    int m_rev;
    int m_last;     // -1 down, 0 none, +1 up
    int m_locked;
    int m_inc;
    int m_dec;
    bit m_active;   // tracking begins the cycle after en is seen high

    // Scoreboard: {level, coarse_inc, coarse_dec, locked}
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_therm(input int k);
        int full;
        full = (1 << N_FINE) - 1;
        return full & ~((1 << (N_FINE - k)) - 1);
    endfunction

    task automatic model_reset();
        m_level  = INIT_LEVEL;
        m_acc    = 0;
        m_settle = 0;
        m_rev    = 0;
        m_last   = 0;
        m_locked = 0;
        m_inc    = 0;
        m_dec    = 0;
        m_active = 1'b0;
    endtask

    task automatic lock_clear();
        m_rev    = 0;
        m_last   = 0;
        m_locked = 0;
    endtask

    task automatic fine_step(input int d);
        m_level = m_level + d;
        if (m_last != 0 && m_last != d) begin
            if (m_rev < LOCK_TOGGLES) m_rev = m_rev + 1;
        end else if (m_last == d) begin
            m_rev = 0;
        end
        m_locked = (m_rev >= LOCK_TOGGLES) ? 1 : 0;
        m_last   = d;
    endtask

    task automatic model_step();
        int d;
        m_inc = 0;
        m_dec = 0;
        if (!en) begin
            m_active = 1'b0;
            m_acc    = 0;
            m_settle = 0;
            lock_clear();
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
        end else if (pd_valid) begin
            m_acc = m_acc + (pd_up ? 1 : -1);
            if (m_acc == FILT_TH || m_acc == -FILT_TH) begin
                d     = (m_acc > 0) ? 1 : -1;
                m_acc = 0;
                if (m_level + d >= 0 && m_level + d <= N_FINE) begin
                    fine_step(d);
                end else if (d > 0 && !coarse_at_max) begin
                    m_inc    = 1;
                    m_level  = 0;
                    m_settle = SETTLE;
                    lock_clear();
                end else if (d < 0 && !coarse_at_min) begin
                    m_dec    = 1;
                    m_level  = N_FINE;
                    m_settle = SETTLE;
                    lock_clear();
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_q.push_back({LW'(m_level), 1'(m_inc), 1'(m_dec), 1'(m_locked)});
    endtask

    task automatic check_outputs(input string tag);
        logic [EW-1:0] e;
        int            lv;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e  = exp_q.pop_front();
            lv = int'(e[EW-1:3]);
            chk({tag, "_level"},  32'(level),      32'(lv));
            chk({tag, "_therm"},  32'(therm_q),    32'(exp_therm(lv)));
            chk({tag, "_onehot"}, 32'(sel_onehot), 32'(1 << lv));
            chk({tag, "_inc"},    32'(coarse_inc), 32'(e[2]));
            chk({tag, "_dec"},    32'(coarse_dec), 32'(e[1]));
            chk({tag, "_locked"}, 32'(locked),     32'(e[0]));
        end
    endtask

    // Driver: one clock edge, model update, check 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        push_expected();
        #1;
        check_outputs("cyc");
    endtask

    task automatic pd_burst(input bit up, input int n);
        for (int i = 0; i < n; i++) begin
            pd_valid = 1'b1;
            pd_up    = up;
            tick();
        end
        pd_valid = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        pd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset asserted mid-cycle; outputs must change before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_expected();
        check_outputs(tag);
    endtask

    initial begin
        int bias;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("reset_level",  32'(level),      32'd0);
        chk("reset_therm",  32'(therm_q),    32'h00);
        chk("reset_onehot", 32'(sel_onehot), 32'h01);

        // Enable, then step up through the fine range
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        pd_burst(1'b1, 4);
        chk("up1_level",  32'(level),      32'd1);
        chk("up1_therm",  32'(therm_q),    32'h20);
        chk("up1_onehot", 32'(sel_onehot), 32'h02);
        pd_burst(1'b1, 20);
        chk("up6_level",  32'(level),      32'd6);
        chk("up6_therm",  32'(therm_q),    32'h3f);
        chk("up6_onehot", 32'(sel_onehot), 32'h40);

        // Carry to coarse line, then settle window drops 4 samples
        coarse_at_max = 1'b0;
        pd_burst(1'b1, 4);
        chk("carry_pulse", 32'(coarse_inc), 32'd1);
        chk("carry_level", 32'(level),      32'd0);
        pd_burst(1'b1, 7);
        chk("settle_drop_level", 32'(level), 32'd0);
        pd_burst(1'b1, 1);
        chk("after_settle_level", 32'(level), 32'd1);

        // Saturation at the top with the coarse line at max
        pd_burst(1'b1, 20);
        coarse_at_max = 1'b1;
        pd_burst(1'b1, 4);
        chk("sat_top_level", 32'(level),      32'd6);
        chk("sat_top_pulse", 32'(coarse_inc), 32'd0);
        coarse_at_max = 1'b0;

        // Borrow from coarse line at level 0
        pd_burst(1'b0, 24);
        coarse_at_min = 1'b0;
        pd_burst(1'b0, 4);
        chk("borrow_pulse", 32'(coarse_dec), 32'd1);
        chk("borrow_level", 32'(level),      32'd6);
        idle_ticks(SETTLE);

        // Lock from alternating bursts starting at level 3
        pd_burst(1'b0, 12);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        for (int b = 0; b < 5; b++) begin
            pd_burst((b % 2) == 0, 4);
            if (b == 3) chk("lock_not_yet", 32'(locked), 32'd0);
        end
        chk("lock_set",       32'(locked), 32'd1);
        chk("lock_set_level", 32'(level),  32'd4);
        pd_burst(1'b1, 4);
        chk("lock_cleared", 32'(locked), 32'd0);
        pd_burst(1'b1, 4);
        chk("lock_up_level", 32'(level), 32'd6);

        // Drop enable with the accumulator at +3
        pd_burst(1'b1, 3);
        en = 1'b0;
        tick();
        chk("en_drop_level",  32'(level),  32'd6);
        chk("en_drop_locked", 32'(locked), 32'd0);
        en = 1'b1;
        tick();
        pd_burst(1'b1, 3);
        chk("acc_cleared_level", 32'(level),      32'd6);
        chk("acc_cleared_pulse", 32'(coarse_inc), 32'd0);
        pd_burst(1'b1, 1);
        chk("carry2_pulse", 32'(coarse_inc), 32'd1);

        // Async reset during a carry pulse
        async_reset("rst_pulse");
        chk("rst_pulse_inc", 32'(coarse_inc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pd_burst(1'b0, 4);
        chk("borrow2_level", 32'(level), 32'd6);
        idle_ticks(1);

        // Async reset while settling
        async_reset("rst_settle");
        chk("rst_settle_level", 32'(level),   32'd0);
        chk("rst_settle_therm", 32'(therm_q), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized phase
        bias = 50;
        for (int i = 0; i < 480; i++) begin
            if ((i % 60) == 0) bias = $urandom_range(0, 2) * 40 + 10;
            en            = ($urandom_range(0, 39) != 0);
            pd_valid      = ($urandom_range(0, 3) != 0);
            pd_up         = ($urandom_range(0, 99) < bias);
            coarse_at_max = ($urandom_range(0, 3) == 0);
            coarse_at_min = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
